seq_timing_skid_rx: RTL
=======================

Name: seq_timing_skid_rx

Overview:
- Clocked receiver stage for a byte-wide valid/ready stream: accepts words from an upstream writer and presents them to a downstream consumer.
- 2-entry skid buffer, so upstream can stream at full rate while downstream stalls by one cycle.
- Every storage element uses only the supported form: a single posedge clock event plus an asynchronous reset event. This makes it the supported-extraction counterpart for sequential timing benchmarks.
- Also counts delivered words.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1..64)
- CNT_W, 16, width of delivered-word counter

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word valid
- in_data  input  WIDTH  upstream word
- in_ready  output  1  block can accept a word this cycle (registered)
- out_valid  output  1  out_data holds a valid word
- out_data  output  WIDTH  head word
- out_ready  input  1  downstream accepts the head word
- xfer_count  output  CNT_W  number of words delivered downstream, modulo 2^CNT_W
- overflow_err  output  1  sticky flag: in_valid was high while in_ready was low

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Reset (rst_n low, asynchronous, effective immediately without a clock edge):
  - state=EMPTY, in_ready=0, out_valid=0, out_data=0, skid=0, xfer_count=0, overflow_err=0.
- First posedge after rst_n rises: in_ready goes to 1. No word is accepted on that edge, because in_ready was 0 during it.
- States: EMPTY (0 words), ONE (head valid), FULL (head and skid valid).
  - out_valid = (state != EMPTY); it is decoded from registered state.
  - in_ready is registered: next in_ready = (next_state != FULL).
- Transitions:
  - EMPTY:
    - in_fire -> head<=in_data, ONE.
    - Otherwise stay.
    - out_ready is ignored.
  - ONE:
    - in_fire & out_fire -> head<=in_data, stay ONE.
    - in_fire & !out_fire -> skid<=in_data, FULL.
    - !in_fire & out_fire -> EMPTY; head keeps its old value.
    - Neither -> hold.
  - FULL (in_ready=0):
    - out_fire -> head<=skid, ONE.
    - Otherwise hold.
    - in_data is ignored.
- Latency and throughput:
  - A word accepted on edge N is visible on out_data/out_valid after edge N (zero bubbles when EMPTY).
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Ordering: strict FIFO; no word is dropped or duplicated.
- xfer_count:
  - Increments by 1 on each out_fire edge.
  - Wraps from 2^CNT_W-1 to 0 silently.
- overflow_err:
  - Set on any edge where in_valid=1 and in_ready=0, outside the first post-reset cycle.
  - Cleared only by reset.
  - The offered word is not stored.
- Reset mid-transfer: all buffered words are discarded and the counter clears. The first post-reset cycle has in_ready=0, so upstream must hold or re-present the word.
- There is no combinational path from out_ready to in_ready (in_ready is a register output).

Decomposition:
- Shared package seq_timing_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_t
  - localparam DEFAULT_WIDTH = 8
- One natural sub-module: seq_timing_wrap_counter (parameter CNT_W; ports clk, rst_n, inc, count). It is the CNT_W-bit wrapping counter with async active-low reset, reused by other benchmarks.
- Everything else stays flat in one always_ff plus one always_comb next-state block.

Test Plan:
- Reset release, WIDTH=8:
  - Hold rst_n=0 for 3 cycles: out_valid=0, in_ready=0, xfer_count=0.
  - Release: in_ready=1 after first edge.
  - Drive rst_n low mid-cycle: outputs clear without a clock edge.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 on the next three cycles, xfer_count=3, in_ready stays 1.
- Stall/fill:
  - out_ready=0, push 0xA5 then 0x5A -> state FULL, in_ready=0 after second edge.
  - Raise out_ready -> 0xA5 then 0x5A delivered in order; in_ready returns to 1 one edge after the first pop.
- Simultaneous push/pop in ONE: head=0x01, in_valid=1 with 0x02, out_ready=1 -> head becomes 0x02, state stays ONE, xfer_count+1.
- Overflow: in FULL, drive in_valid=1 with 0xFF -> overflow_err=1 after the edge, 0xFF never appears on out_data, and the flag stays set until reset.
- Counter wrap (CNT_W=4): deliver 17 words -> xfer_count reads 15 after word 15, 0 after word 16, 1 after word 17.

Source files
------------

// File: rtl/seq_timing_pkg.sv
// Shared types and defaults for the sequential-timing receiver blocks.
package seq_timing_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : seq_timing_pkg

// File: rtl/seq_timing_wrap_counter.sv
// Free-running CNT_W-bit event counter; wraps silently to zero.
module seq_timing_wrap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: add one per event, natural overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : seq_timing_wrap_counter

// File: rtl/seq_timing_skid_rx.sv
// Valid/ready receiver stage with a 2-entry skid buffer (head + skid),
// registered in_ready, delivered-word counter and sticky overflow flag.
module seq_timing_skid_rx
  import seq_timing_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count,
  output logic             overflow_err
);

  skid_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             overflow_q, overflow_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Next-state, buffer steering, registered-ready and overflow decode.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          head_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    in_ready_d = (state_d != ST_FULL);
    // in_ready is low only in FULL or in the first cycle after reset;
    // qualifying with FULL excludes that post-reset cycle.
    overflow_d = overflow_q | (in_valid & ~in_ready_q & (state_q == ST_FULL));
  end

  // All buffer state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      overflow_q <= overflow_d;
    end
  end

  seq_timing_wrap_counter #(
    .CNT_W(CNT_W)
  ) u_xfer_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_fire),
    .count(xfer_count)
  );

  assign in_ready     = in_ready_q;
  assign out_data     = head_q;
  assign overflow_err = overflow_q;

endmodule : seq_timing_skid_rx
